// File: rtl/sar_pkg.sv
// Shared SAR definitions: controller state encoding and the default resolution,
// which the sampler stage also uses.
package sar_pkg;

    localparam int unsigned NUM_BITS_DEFAULT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

endpackage

// File: rtl/sar_ctrl_if.sv
// SAR controller signal bundle: start/comparator inputs and the conversion outputs.
interface sar_ctrl_if
    import sar_pkg::*;
#(
    parameter int unsigned NUM_BITS = NUM_BITS_DEFAULT
) ();

    logic                sample_sig;
    logic                comp_out;
    logic                hold;
    logic [NUM_BITS-1:0] dac_code;
    logic                busy;
    logic [NUM_BITS-1:0] dout;
    logic                eoc;
    logic                overrun;

    modport master (
        output sample_sig, comp_out,
        input  hold, dac_code, busy, dout, eoc, overrun
    );

    modport slave (
        input  sample_sig, comp_out,
        output hold, dac_code, busy, dout, eoc, overrun
    );

endinterface

// File: rtl/sar_ctrl.sv
// Successive-approximation controller: one binary-search decision per clock,
// result published on dout with a one-cycle eoc strobe.
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned NUM_BITS = NUM_BITS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    sar_ctrl_if.slave  bus
);

    localparam int unsigned IDX_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_BITS - 1);
    localparam logic [NUM_BITS-1:0] MSB_CODE = NUM_BITS'(1) << MAX_IDX;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_BITS-1:0] dac_q, dac_d;
    logic [NUM_BITS-1:0] dout_q, dout_d;
    logic                hold_q, hold_d;
    logic                busy_q, busy_d;
    logic                eoc_q, eoc_d;
    logic                ovr_q, ovr_d;
    logic [NUM_BITS-1:0] mask;
    logic [NUM_BITS-1:0] resolved;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= MAX_IDX;
            dac_q   <= '0;
            dout_q  <= '0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            eoc_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dac_q   <= dac_d;
            dout_q  <= dout_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            eoc_q   <= eoc_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state and code/mask update
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dac_d    = dac_q;
        dout_d   = dout_q;
        hold_d   = hold_q;
        busy_d   = busy_q;
        eoc_d    = 1'b0;
        ovr_d    = 1'b0;
        mask     = NUM_BITS'(1) << idx_q;
        resolved = bus.comp_out ? dac_q : (dac_q & ~mask);

        case (state_q)
            IDLE: begin
                hold_d = 1'b0;
                busy_d = 1'b0;
                dac_d  = '0;
                idx_d  = MAX_IDX;
                if (bus.sample_sig) begin
                    state_d = CONV;
                    hold_d  = 1'b1;
                    busy_d  = 1'b1;
                    dac_d   = MSB_CODE;
                end
            end
            CONV: begin
                // A start request during a conversion is dropped and flagged.
                ovr_d = bus.sample_sig;
                if (idx_q != '0) begin
                    dac_d = resolved | (mask >> 1);
                    idx_d = idx_q - IDX_W'(1);
                end else begin
                    dout_d  = resolved;
                    eoc_d   = 1'b1;
                    state_d = IDLE;
                    hold_d  = 1'b0;
                    busy_d  = 1'b0;
                    dac_d   = '0;
                    idx_d   = MAX_IDX;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.hold     = hold_q;
    assign bus.busy     = busy_q;
    assign bus.dac_code = dac_q;
    assign bus.dout     = dout_q;
    assign bus.eoc      = eoc_q;
    assign bus.overrun  = ovr_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Self-checking bench for sar_ctrl: behavioural conversion model checked every
// cycle, plus directed literal checks on the test-plan scenarios.
module tb_sar_ctrl;

    localparam int unsigned NB = 4;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] vin;
    int            n_vec;
    int            n_err;
    int            n_eoc;
    int            n_ovr;
    bit            chk_en;

    sar_ctrl_if #(.NUM_BITS(NB)) ifc ();

    sar_ctrl #(.NUM_BITS(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    // Behavioural comparator: Vin >= Vdac
    function automatic logic sar_comp_model(input logic [NB-1:0] v, input logic [NB-1:0] code);
        return v >= code;
    endfunction

    assign ifc.comp_out = sar_comp_model(vin, ifc.dac_code);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Reference model: step = decisions already taken, -1 when idle
    int            m_step;
    logic [NB-1:0] m_vin;
    logic [NB-1:0] m_dout;
    logic          m_eoc;
    logic          m_ovr;

    // Trial code after k decisions: resolved upper k bits of Vin plus the next trial bit
    function automatic logic [NB-1:0] trial_code(input int k, input logic [NB-1:0] v);
        logic [NB-1:0] hi;
        hi = NB'(~((1 << (NB - k)) - 1));
        return (v & hi) | NB'(1 << (NB - 1 - k));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_step <= -1;
            m_vin  <= '0;
            m_dout <= '0;
            m_eoc  <= 1'b0;
            m_ovr  <= 1'b0;
        end else begin
            m_eoc <= 1'b0;
            m_ovr <= 1'b0;
            if (m_step < 0) begin
                if (ifc.sample_sig) begin
                    m_step <= 0;
                    m_vin  <= vin;
                end
            end else begin
                m_ovr <= ifc.sample_sig;
                if (m_step == NB - 1) begin
                    m_step <= -1;
                    m_eoc  <= 1'b1;
                    m_dout <= m_vin;
                end else begin
                    m_step <= m_step + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("model_hold",    32'(ifc.hold),     32'(m_step >= 0));
            chk("model_busy",    32'(ifc.busy),     32'(m_step >= 0));
            chk("model_dac",     32'(ifc.dac_code), (m_step >= 0) ? 32'(trial_code(m_step, m_vin)) : 32'd0);
            chk("model_dout",    32'(ifc.dout),     32'(m_dout));
            chk("model_eoc",     32'(ifc.eoc),      32'(m_eoc));
            chk("model_overrun", 32'(ifc.overrun),  32'(m_ovr));
            if (ifc.eoc === 1'b1)     n_eoc++;
            if (ifc.overrun === 1'b1) n_ovr++;
        end
    end

    // One conversion from a sample pulse; returns at edge T+5 with endpoint checks done
    task automatic conv(input logic [NB-1:0] v, input string tag);
        vin = v;
        ifc.sample_sig = 1'b1;
        tick(1);
        ifc.sample_sig = 1'b0;
        for (int k = 0; k < NB; k++) begin
            chk({tag, "_hold_hi"}, 32'(ifc.hold), 32'd1);
            tick(1);
        end
        chk({tag, "_hold_lo"}, 32'(ifc.hold), 32'd0);
        chk({tag, "_eoc"},     32'(ifc.eoc),  32'd1);
        chk({tag, "_dout"},    32'(ifc.dout), 32'(v));
    endtask

    logic [NB-1:0] seq11 [NB];
    int            eoc0;
    int            ovr0;
    logic [NB-1:0] rv;

    initial begin
        n_vec = 0; n_err = 0; n_eoc = 0; n_ovr = 0; chk_en = 1'b0;
        rst_n = 1'b0;
        ifc.sample_sig = 1'b0;
        vin = '0;
        seq11[0] = 4'b1000; seq11[1] = 4'b1100; seq11[2] = 4'b1010; seq11[3] = 4'b1011;

        #12;
        chk("rst_hold",    32'(ifc.hold),     32'd0);
        chk("rst_busy",    32'(ifc.busy),     32'd0);
        chk("rst_dac",     32'(ifc.dac_code), 32'd0);
        chk("rst_dout",    32'(ifc.dout),     32'd0);
        chk("rst_eoc",     32'(ifc.eoc),      32'd0);
        chk("rst_overrun", 32'(ifc.overrun),  32'd0);
        tick(1);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick(2);

        // Vin = 11: literal trial-code sequence
        vin = 4'd11;
        ifc.sample_sig = 1'b1;
        tick(1);
        ifc.sample_sig = 1'b0;
        for (int k = 0; k < NB; k++) begin
            chk("v11_dac_seq", 32'(ifc.dac_code), 32'(seq11[k]));
            chk("v11_eoc_lo",  32'(ifc.eoc),      32'd0);
            tick(1);
        end
        chk("v11_eoc",  32'(ifc.eoc),  32'd1);
        chk("v11_dout", 32'(ifc.dout), 32'd11);
        chk("v11_hold", 32'(ifc.hold), 32'd0);
        tick(3);

        // Range extremes
        conv(4'd0, "v0");
        tick(2);
        conv(4'd15, "v15");
        tick(2);

        // Back-to-back at the fastest rate
        ovr0 = n_ovr;
        eoc0 = n_eoc;
        for (int i = 0; i < 8; i++) begin
            rv = NB'($urandom_range(0, 15));
            conv(rv, "b2b");
        end
        tick(1);
        chk("b2b_eoc_count", 32'(n_eoc - eoc0), 32'd8);
        chk("b2b_no_overrun", 32'(n_ovr - ovr0), 32'd0);
        tick(2);

        // Start request during a conversion
        ovr0 = n_ovr;
        eoc0 = n_eoc;
        vin = 4'd6;
        ifc.sample_sig = 1'b1;
        tick(1);
        ifc.sample_sig = 1'b0;
        tick(2);
        ifc.sample_sig = 1'b1;
        tick(1);
        ifc.sample_sig = 1'b0;
        chk("ovr_pulse", 32'(ifc.overrun), 32'd1);
        tick(1);
        chk("ovr_eoc",      32'(ifc.eoc),     32'd1);
        chk("ovr_dout",     32'(ifc.dout),    32'd6);
        chk("ovr_one_shot", 32'(ifc.overrun), 32'd0);
        tick(3);
        chk("ovr_no_restart", 32'(ifc.busy), 32'd0);
        chk("ovr_eoc_count",  32'(n_eoc - eoc0), 32'd1);
        chk("ovr_count",      32'(n_ovr - ovr0), 32'd1);

        // Reset mid-conversion
        eoc0 = n_eoc;
        vin = 4'd9;
        ifc.sample_sig = 1'b1;
        tick(1);
        ifc.sample_sig = 1'b0;
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("mrst_hold", 32'(ifc.hold),     32'd0);
        chk("mrst_busy", 32'(ifc.busy),     32'd0);
        chk("mrst_dac",  32'(ifc.dac_code), 32'd0);
        chk("mrst_dout", 32'(ifc.dout),     32'd0);
        chk("mrst_eoc",  32'(ifc.eoc),      32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("mrst_no_eoc", 32'(n_eoc - eoc0), 32'd0);
        conv(4'd9, "v9_after_rst");
        tick(2);

        // Sample held high for two cycles
        ovr0 = n_ovr;
        eoc0 = n_eoc;
        vin = 4'd5;
        ifc.sample_sig = 1'b1;
        tick(2);
        ifc.sample_sig = 1'b0;
        chk("dbl_overrun", 32'(ifc.overrun), 32'd1);
        tick(5);
        chk("dbl_eoc_count", 32'(n_eoc - eoc0), 32'd1);
        chk("dbl_ovr_count", 32'(n_ovr - ovr0), 32'd1);
        chk("dbl_dout",      32'(ifc.dout),     32'd5);
        chk("dbl_idle",      32'(ifc.busy),     32'd0);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sar_ctrl.md
# sar_ctrl

Successive-approximation control stage directly downstream of the sample-rate generator. Each `sample_sig` pulse puts the analog front end into hold, then the block runs one binary-search decision per clock against the comparator and drives the trial code to the capacitive DAC. It publishes the final `NUM_BITS` result with a one-cycle end-of-conversion strobe. A conversion fits exactly in the fastest sample period of `NUM_BITS+1` clocks.

## Interface
- `NUM_BITS`, 4, ADC resolution; also sets conversion length.

- `clk`  in  1  system clock (100 MHz nominal).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sample_sig`  in  1  one-cycle start pulse from the sampler stage.
- `comp_out`  in  1  comparator result: 1 when Vin >= Vdac(`dac_code`). Valid within the cycle `dac_code` is driven.
- `hold`  out  1  0 = track, 1 = hold; drives the track/hold switch.
- `dac_code`  out  NUM_BITS  current trial code to the DAC.
- `busy`  out  1  conversion in progress.
- `dout`  out  NUM_BITS  last completed result; held between conversions.
- `eoc`  out  1  one-cycle pulse, coincident with `dout` update.
- `overrun`  out  1  one-cycle pulse when `sample_sig` arrives while busy.

## Operation
- States: `IDLE`, `CONV`.
- Reset: state `IDLE`; `hold`, `busy`, `eoc`, `overrun` = 0; `dac_code`, `dout` = 0; internal bit index = `NUM_BITS-1`.
- `IDLE`
  - `hold` = 0 and `dac_code` = 0.
  - On `sample_sig`=1, the state moves to `CONV`.
  - On entry: `hold`=1, `busy`=1, `dac_code` = MSB only (1 << (NUM_BITS-1)), index = `NUM_BITS-1`.
- `CONV`, on each clock:
  - Take `mask` = 1 << index.
  - If `comp_out`=0, clear bit index of `dac_code`.
  - If index > 0: set bit index-1 and decrement index.
  - If index == 0: this is the final decision.
    - `dout` <= resolved code; `eoc` <= 1.
    - State goes to `IDLE`; `hold`, `busy` <= 0; `dac_code` <= 0; index reloads `NUM_BITS-1`.
- Arithmetic: `next` = (`dac_code` & ~(`comp_out` ? 0 : `mask`)) | (`mask` >> 1). At index 0 the shifted mask is 0. All operations are `NUM_BITS` wide, with no carry.
- A `sample_sig` seen in `CONV`:
  - It is ignored; the conversion continues unchanged.
  - `overrun` pulses the following cycle.
  - This includes the final-decision cycle, because the state is still `CONV`.
- A `sample_sig` in the `IDLE` cycle immediately after `eoc` starts a new conversion normally.
- Reset mid-conversion: everything returns to reset values asynchronously. `dout` is cleared and no `eoc` is issued.

## Timing
- Cycle numbering: `sample_sig` is high at edge-cycle T.
  - Edge T+1: `CONV` entered, `hold`=1, `dac_code` = MSB trial.
  - Edges T+2 … T+NUM_BITS+1: one decision each (`NUM_BITS` decisions).
  - Edge T+NUM_BITS+1: `eoc`=1, `dout` valid, `hold`=0.
- Latency from `sample_sig` to `eoc` is `NUM_BITS+1` clocks.
- At the fastest rate (period `NUM_BITS+1`), the next pulse lands in the `IDLE` cycle. `hold` is then low for exactly 1 cycle (acquisition window), with no overrun.
- `comp_out` is sampled at the edge ending the cycle in which the corresponding `dac_code` was driven. Comparator plus DAC settling must fit in one clock.
- `eoc` and `overrun` are never high for more than one consecutive cycle.

## Structure
- Shared package `sar_pkg`: state enum (`IDLE`, `CONV`) and the default `NUM_BITS` constant. The sampler stage uses the same constant.
- Single module.
- The code/mask update is one always block; no sub-module is warranted.
- A behavioural comparator model (`sar_comp_model`) belongs in the testbench only.

## Test plan
- `NUM_BITS`=4, Vin=11, single `sample_sig`:
  - Required `dac_code` sequence: 1000, 1100, 1010, 1011.
  - `eoc` at T+5 with `dout`=1011.
- Vin=0 gives `dout`=0000; Vin=15 gives `dout`=1111. Check `hold` high on T+1 through T+4 only.
- Back-to-back `sample_sig` every 5 clocks for 8 conversions with random Vin:
  - Every result matches Vin; `overrun` never asserts.
  - `hold` is low exactly 1 cycle between conversions.
- `sample_sig` at T+3 during a conversion (Vin=6):
  - `overrun` pulses at T+4.
  - `dout`=0110 at T+5.
  - No second conversion starts.
- Assert `rst_n`=0 at T+3 (Vin=9):
  - All outputs are 0 immediately.
  - No `eoc`; the next `sample_sig` converts 9 correctly.
- `sample_sig` held high for 2 cycles:
  - One conversion runs.
  - `overrun` pulses once.
